multicycle_controller: RTL and testbench

- Multi-cycle control unit for the 32-bit MIPS datapath.
- Owns the instruction register and fetches over a req/ack instruction-memory port.
- Decodes each instruction and drives the datapath selects (pcsel, wasel, wdsel, asel, sext, bsel, alufn, wr, werf), plus pc_en, which gates the datapath PC update.
- Sequences data-memory accesses over a req/ack port, stalling until ack, so the datapath can sit behind variable-latency memories.

---
 rtl/multicycle_controller.sv | 158 +++++++++++++++
 tb/tb_multicycle_controller.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control unit: owns the instruction register, fetches and
// accesses data memory over req/ack ports, and drives the datapath selects.
module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        pc_en,
  output logic [1:0]  pcsel,
  output logic [1:0]  wasel,
  output logic [1:0]  wdsel,
  output logic [1:0]  asel,
  output logic        sext,
  output logic        bsel,
  output logic [4:0]  alufn,
  output logic        wr,
  output logic        werf,
  input  logic        Z,
  output logic        dmem_req,
  input  logic        dmem_ack,
  output logic        illegal,
  output logic [31:0] retired
);
  localparam logic [4:0] ALU_ADD = 5'b00001;
  localparam logic [4:0] ALU_SUB = 5'b10001;
  localparam logic [4:0] ALU_AND = 5'b00100;
  localparam logic [4:0] ALU_OR  = 5'b00110;
  localparam logic [4:0] ALU_SLT = 5'b10011;
  localparam logic [4:0] ALU_SLL = 5'b01000;
  localparam logic [4:0] ALU_SRL = 5'b01010;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, TRAP} state_t;
  state_t state, next_state;

  logic [5:0] op, funct;
  logic [1:0] d_pcsel, d_wasel, d_wdsel, d_asel;
  logic       d_sext, d_bsel, d_wf, d_branch, d_bne, d_mem, d_sw, d_illegal;
  logic [4:0] d_alufn;

  logic [1:0] pcsel_q;
  logic       wf_q, branch_q, bne_q, sw_q;

  assign op    = instr[31:26];
  assign funct = instr[5:0];

  always_comb begin
    d_pcsel = '0; d_wasel = '0; d_wdsel = '0; d_asel = '0;
    d_sext = 1'b0; d_bsel = 1'b0; d_alufn = '0; d_wf = 1'b0;
    d_branch = 1'b0; d_bne = 1'b0; d_mem = 1'b0; d_sw = 1'b0; d_illegal = 1'b0;
    case (op)
      6'h00: begin
        d_wdsel = 2'b01;
        d_wf    = 1'b1;
        case (funct)
          6'h20: d_alufn = ALU_ADD;
          6'h22: d_alufn = ALU_SUB;
          6'h24: d_alufn = ALU_AND;
          6'h25: d_alufn = ALU_OR;
          6'h2A: d_alufn = ALU_SLT;
          6'h00: begin d_asel = 2'b01; d_alufn = ALU_SLL; end
          6'h02: begin d_asel = 2'b01; d_alufn = ALU_SRL; end
          6'h08: begin d_pcsel = 2'b11; d_wdsel = '0; d_wf = 1'b0; end
          default: begin d_illegal = 1'b1; d_wdsel = '0; d_wf = 1'b0; end
        endcase
      end
      6'h08, 6'h0A: begin
        d_sext = 1'b1; d_bsel = 1'b1; d_wasel = 2'b01; d_wdsel = 2'b01; d_wf = 1'b1;
        d_alufn = (op == 6'h08) ? ALU_ADD : ALU_SLT;
      end
      6'h0C, 6'h0D: begin
        d_bsel = 1'b1; d_wasel = 2'b01; d_wdsel = 2'b01; d_wf = 1'b1;
        d_alufn = (op == 6'h0C) ? ALU_AND : ALU_OR;
      end
      6'h0F: begin
        d_asel = 2'b10; d_bsel = 1'b1; d_alufn = ALU_SLL;
        d_wasel = 2'b01; d_wdsel = 2'b01; d_wf = 1'b1;
      end
      6'h23: begin
        d_sext = 1'b1; d_bsel = 1'b1; d_alufn = ALU_ADD;
        d_wasel = 2'b01; d_wdsel = 2'b10; d_wf = 1'b1; d_mem = 1'b1;
      end
      6'h2B: begin
        d_sext = 1'b1; d_bsel = 1'b1; d_alufn = ALU_ADD; d_mem = 1'b1; d_sw = 1'b1;
      end
      6'h04, 6'h05: begin
        d_alufn = ALU_SUB; d_sext = 1'b1; d_branch = 1'b1; d_bne = (op == 6'h05);
      end
      6'h02: d_pcsel = 2'b10;
      6'h03: begin d_pcsel = 2'b10; d_wasel = 2'b10; d_wf = 1'b1; end
      default: d_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:   if (imem_ack) next_state = DECODE;
      DECODE:  next_state = d_illegal ? TRAP : (d_mem ? MEM : EXEC);
      EXEC:    next_state = FETCH;
      MEM:     if (dmem_ack) next_state = FETCH;
      TRAP:    next_state = TRAP;
      default: next_state = FETCH;
    endcase
  end

  always_comb begin
    imem_req = (state == FETCH) && !reset;
    dmem_req = (state == MEM);
    wr       = (state == MEM) && sw_q;
    pc_en    = (state == EXEC) || ((state == MEM) && dmem_ack);
    werf     = pc_en && wf_q;
    // Branch decision needs the live Z flag, so it bypasses the registered select.
    pcsel    = ((state == EXEC) && branch_q) ? {1'b0, Z ^ bne_q} : pcsel_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr    <= '0;
      illegal  <= 1'b0;
      retired  <= '0;
      pcsel_q  <= '0;
      wasel    <= '0;
      wdsel    <= '0;
      asel     <= '0;
      sext     <= 1'b0;
      bsel     <= 1'b0;
      alufn    <= '0;
      wf_q     <= 1'b0;
      branch_q <= 1'b0;
      bne_q    <= 1'b0;
      sw_q     <= 1'b0;
    end else begin
      if (state == FETCH && imem_ack) instr <= imem_rdata;
      if (state == DECODE) begin
        pcsel_q  <= d_pcsel;
        wasel    <= d_wasel;
        wdsel    <= d_wdsel;
        asel     <= d_asel;
        sext     <= d_sext;
        bsel     <= d_bsel;
        alufn    <= d_alufn;
        wf_q     <= d_wf;
        branch_q <= d_branch;
        bne_q    <= d_bne;
        sw_q     <= d_sw;
        if (d_illegal) illegal <= 1'b1;
      end
      if (pc_en) retired <= retired + 32'd1;
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: expected select sets are queued
// per instruction and compared on the completion (pc_en) cycle.
module tb_multicycle_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack;
  logic [31:0] imem_rdata, instr;
  logic        pc_en;
  logic [1:0]  pcsel, wasel, wdsel, asel;
  logic        sext, bsel, wr, werf, Z, dmem_req, dmem_ack, illegal;
  logic [4:0]  alufn;
  logic [31:0] retired;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .pc_en(pc_en), .pcsel(pcsel),
    .wasel(wasel), .wdsel(wdsel), .asel(asel), .sext(sext), .bsel(bsel),
    .alufn(alufn), .wr(wr), .werf(werf), .Z(Z), .dmem_req(dmem_req),
    .dmem_ack(dmem_ack), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] pcsel, wasel, wdsel, asel;
    logic       sext, bsel;
    logic [4:0] alufn;
    logic       werf, wr;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned model_retired = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("werf_only_with_pc_en", {31'd0, werf & ~pc_en}, 32'd0);
      if (pc_en) begin
        if (sb.size() == 0) check("unexpected_pc_en", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("pcsel", {30'd0, pcsel}, {30'd0, e.pcsel});
          check("wasel", {30'd0, wasel}, {30'd0, e.wasel});
          check("wdsel", {30'd0, wdsel}, {30'd0, e.wdsel});
          check("asel",  {30'd0, asel},  {30'd0, e.asel});
          check("sext",  {31'd0, sext},  {31'd0, e.sext});
          check("bsel",  {31'd0, bsel},  {31'd0, e.bsel});
          check("alufn", {27'd0, alufn}, {27'd0, e.alufn});
          check("werf",  {31'd0, werf},  {31'd0, e.werf});
          check("wr",    {31'd0, wr},    {31'd0, e.wr});
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 with the DUT back in FETCH.
  task automatic run(input logic [31:0] ins, input int dly, input logic z,
                     input logic spur, input exp_t e);
    int  cyc = 0, nreq = 0, cnt = 0;
    bit  started = 0, done = 0;
    sb.push_back(e);
    imem_rdata = ins; imem_ack = 1'b1; Z = z; dmem_ack = spur;
    if (imem_req) begin started = 1; cyc = 1; end
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      if (dmem_req) cnt++;
      dmem_ack = dmem_req ? (cnt > dly) : spur;
      @(negedge clk);
      if (imem_req) started = 1;
      if (started) cyc++;
      if (dmem_req) nreq++;
      if (pc_en) done = 1;
    end
    imem_ack = 1'b0;
    check("completed", {31'd0, done}, 32'd1);
    check("latency", cyc, (e.wr || e.wdsel == 2'b10) ? 3 + dly : 3);
    check("dmem_req_cycles", nreq, (e.wr || e.wdsel == 2'b10) ? dly + 1 : 0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    model_retired++;
    check("retired", retired, model_retired);
    check("back_in_fetch", {31'd0, imem_req}, 32'd1);
  endtask

  localparam logic [4:0] ADD = 5'b00001, SUB = 5'b10001, OR_ = 5'b00110,
                         SLT = 5'b10011, SLL = 5'b01000;

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; Z = 1'b0; dmem_ack = 1'b0;
    #12;
    check("rst_instr", instr, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_sels", {pcsel, wasel, wdsel, asel, sext, bsel, alufn}, 32'd0);
    check("rst_strobes", {28'd0, pc_en, werf, wr, dmem_req}, 32'd0);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1; reset = 1'b0; #1;
    check("imem_req_after_rst", {31'd0, imem_req}, 32'd1);

    run(32'h20010005, 0, 1'b0, 1'b1, '{2'd0, 2'd1, 2'd1, 2'd0, 1'b1, 1'b1, ADD, 1'b1, 1'b0});
    run(32'h8C020004, 3, 1'b0, 1'b0, '{2'd0, 2'd1, 2'd2, 2'd0, 1'b1, 1'b1, ADD, 1'b1, 1'b0});
    run(32'hAC020008, 0, 1'b0, 1'b0, '{2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, ADD, 1'b0, 1'b1});
    run(32'h10000003, 0, 1'b1, 1'b0, '{2'd1, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, SUB, 1'b0, 1'b0});
    run(32'h10000003, 0, 1'b0, 1'b0, '{2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, SUB, 1'b0, 1'b0});
    run(32'h14000003, 0, 1'b0, 1'b0, '{2'd1, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, SUB, 1'b0, 1'b0});
    run(32'h0C000010, 0, 1'b0, 1'b0, '{2'd2, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0});
    run(32'h03E00008, 0, 1'b0, 1'b0, '{2'd3, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0});
    run(32'h3C011234, 0, 1'b0, 1'b0, '{2'd0, 2'd1, 2'd1, 2'd2, 1'b0, 1'b1, SLL, 1'b1, 1'b0});
    run(32'h00011080, 0, 1'b0, 1'b0, '{2'd0, 2'd0, 2'd1, 2'd1, 1'b0, 1'b0, SLL, 1'b1, 1'b0});
    run(32'h0022182A, 0, 1'b0, 1'b0, '{2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0, SLT, 1'b1, 1'b0});
    run(32'h34210F0F, 2, 1'b0, 1'b1, '{2'd0, 2'd1, 2'd1, 2'd0, 1'b0, 1'b1, OR_, 1'b1, 1'b0});
    check("instr_reg", instr, 32'h34210F0F);

    // Unsupported opcode: expect a permanent trap until reset.
    imem_rdata = 32'hFC000000; imem_ack = 1'b1; dmem_ack = 1'b1;
    for (int i = 0; i < 10 && !illegal; i++) @(negedge clk);
    check("illegal_set", {31'd0, illegal}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("trap_quiet", {27'd0, pc_en, werf, wr, dmem_req, imem_req}, 32'd0);
    end
    check("trap_retired", retired, model_retired);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    #2 reset = 1'b1; #1;
    check("trap_rst_illegal", {31'd0, illegal}, 32'd0);
    check("trap_rst_instr", instr, 32'd0);
    @(posedge clk); #1; reset = 1'b0; #1;
    check("trap_rst_fetch", {31'd0, imem_req}, 32'd1);
    model_retired = 0;

    // sw stalled in MEM, then reset mid-cycle.
    imem_rdata = 32'hAC020008; imem_ack = 1'b1;
    for (int i = 0; i < 10 && !dmem_req; i++) begin @(posedge clk); #1; end
    imem_ack = 1'b0;
    check("sw_in_mem", {30'd0, dmem_req, wr}, 32'd3);
    @(negedge clk); #1;
    reset = 1'b1; #1;
    check("rst_mid_mem_drop", {28'd0, dmem_req, wr, pc_en, werf}, 32'd0);
    check("rst_mid_mem_retired", retired, 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;
    check("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
